// File: rtl/out_buffer.sv
// Output buffer: holds N bodies (posX, posY, optional Mass) and streams them out as
// a valid/ready word stream. Define OUT_BUFFER_MASS_EN to include the Mass array.
module out_buffer #(
  parameter int N        = 256,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                WR_EN,
  input  logic [IDX_BITS-1:0] WR_IDX,
  input  logic [1:0]          WR_SEL,
  input  logic [15:0]         WR_DATA,
  input  logic                START,
  output logic [15:0]         DATA_OUT,
  output logic                M_VALID,
  input  logic                M_READY,
  output logic                M_LAST,
  output logic                BUSY,
  output logic                DONE
);

  localparam int DATA_W = 16;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N - 1);
`ifdef OUT_BUFFER_MASS_EN
  localparam logic [1:0] LAST_PHASE = 2'd2;
`else
  localparam logic [1:0] LAST_PHASE = 2'd1;
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state;
  logic [IDX_BITS-1:0]   r_idx;
  logic [1:0]            r_phase;
  logic [IDX_BITS-1:0]   nxt_idx;
  logic [1:0]            nxt_phase;
  logic [DATA_W-1:0]     nxt_word;
  logic                  wr_ok;

  logic [DATA_W-1:0] pos_x [N];
  logic [DATA_W-1:0] pos_y [N];
`ifdef OUT_BUFFER_MASS_EN
  logic [DATA_W-1:0] mass  [N];
`endif

  assign wr_ok = WR_EN && (state == IDLE) && !RESET_IN;

  // Storage: random-access writes only while idle, contents frozen during a stream
  always_ff @(posedge CLK_IN) begin
    if (wr_ok) begin
      case (WR_SEL)
        2'd0:    pos_x[WR_IDX] <= WR_DATA;
        2'd1:    pos_y[WR_IDX] <= WR_DATA;
`ifdef OUT_BUFFER_MASS_EN
        2'd2:    mass[WR_IDX]  <= WR_DATA;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt_idx   = r_idx;
    nxt_phase = r_phase + 2'd1;
    if (r_phase == LAST_PHASE) begin
      nxt_phase = 2'd0;
      nxt_idx   = r_idx + IDX_BITS'(1);
    end
  end

  always_comb begin
    nxt_word = '0;
    case (nxt_phase)
      2'd0:    nxt_word = pos_x[nxt_idx];
      2'd1:    nxt_word = pos_y[nxt_idx];
`ifdef OUT_BUFFER_MASS_EN
      2'd2:    nxt_word = mass[nxt_idx];
`endif
      default: nxt_word = '0;
    endcase
  end

  // Stream control: the presented word always corresponds to (r_idx, r_phase)
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state    <= IDLE;
      DATA_OUT <= '0;
      M_VALID  <= 1'b0;
      M_LAST   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      r_idx    <= '0;
      r_phase  <= 2'd0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state    <= STREAM;
            BUSY     <= 1'b1;
            r_idx    <= '0;
            r_phase  <= 2'd0;
            DATA_OUT <= pos_x[0];
            M_VALID  <= 1'b1;
            M_LAST   <= 1'b0;
          end
        end
        STREAM: begin
          if (M_VALID && M_READY) begin
            if (M_LAST) begin
              state   <= IDLE;
              BUSY    <= 1'b0;
              M_VALID <= 1'b0;
              M_LAST  <= 1'b0;
              DONE    <= 1'b1;
            end else begin
              r_idx    <= nxt_idx;
              r_phase  <= nxt_phase;
              DATA_OUT <= nxt_word;
              M_LAST   <= (nxt_idx == LAST_IDX) && (nxt_phase == LAST_PHASE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_buffer.sv
// Scoreboard bench for out_buffer (N=4): stimulus pushes expected streams built
// from a body-level model; a negedge monitor pops and compares accepted words.
module tb_out_buffer;
  localparam int N  = 4;
  localparam int IB = 2;
`ifdef OUT_BUFFER_MASS_EN
  localparam int WPB = 3;
`else
  localparam int WPB = 2;
`endif

  typedef struct {
    logic [15:0] data;
    logic        last;
  } word_t;

  logic          CLK_IN, RESET_IN, WR_EN, START, M_READY;
  logic [IB-1:0] WR_IDX;
  logic [1:0]    WR_SEL;
  logic [15:0]   WR_DATA, DATA_OUT;
  logic          M_VALID, M_LAST, BUSY, DONE;

  out_buffer #(.N(N), .IDX_BITS(IB)) dut (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .WR_EN(WR_EN), .WR_IDX(WR_IDX),
    .WR_SEL(WR_SEL), .WR_DATA(WR_DATA), .START(START), .DATA_OUT(DATA_OUT),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_LAST(M_LAST), .BUSY(BUSY), .DONE(DONE)
  );

  logic [15:0] mx [N];
  logic [15:0] my [N];
  logic [15:0] mm [N];
  word_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int accepted = 0;
  bit expect_done = 0;
  bit in_stream = 0;
  int ready_mode = 0;
  bit prev_stall = 0;
  logic [15:0] prev_data;
  logic prev_last;

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  function automatic void model_write(int idx, logic [1:0] sel, logic [15:0] d);
    case (sel)
      2'd0: mx[idx] = d;
      2'd1: my[idx] = d;
`ifdef OUT_BUFFER_MASS_EN
      2'd2: mm[idx] = d;
`endif
      default: ;
    endcase
  endfunction

  task automatic build_expected(output word_t q[$]);
    word_t w;
    q = {};
    for (int b = 0; b < N; b++) begin
      w.data = mx[b]; w.last = 1'b0; q.push_back(w);
      w.data = my[b]; w.last = (WPB == 2) && (b == N - 1); q.push_back(w);
      if (WPB == 3) begin
        w.data = mm[b]; w.last = (b == N - 1); q.push_back(w);
      end
    end
  endtask

  task automatic do_write(int idx, logic [1:0] sel, logic [15:0] d);
    WR_EN = 1'b1; WR_IDX = IB'(idx); WR_SEL = sel; WR_DATA = d;
    tick();
    WR_EN = 1'b0;
    if (!in_stream) model_write(idx, sel, d);
  endtask

  task automatic start_stream(bit with_wr, int idx, logic [1:0] sel, logic [15:0] d);
    word_t snap[$];
    build_expected(snap);
    START = 1'b1;
    if (with_wr) begin
      WR_EN = 1'b1; WR_IDX = IB'(idx); WR_SEL = sel; WR_DATA = d;
    end
    tick();
    START = 1'b0;
    WR_EN = 1'b0;
    if (with_wr) model_write(idx, sel, d);
    foreach (snap[i]) exp_q.push_back(snap[i]);
    in_stream = 1;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s: stream did not complete, %0d words left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
    in_stream = 0;
  endtask

  task automatic wait_accepted(int target, string name);
    int n = 0;
    while (accepted < target && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s: accepted %0d words, required %0d", name, accepted, target);
    end
  endtask

  // Downstream ready pattern
  initial begin
    M_READY = 1'b1;
    forever begin
      @(posedge CLK_IN);
      #1;
      case (ready_mode)
        0:       M_READY = 1'b1;
        1:       M_READY = ~M_READY;
        default: M_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: sampled on the falling edge, ahead of the accepting rising edge
  initial begin
    word_t w;
    forever begin
      @(negedge CLK_IN);
      if (RESET_IN) begin
        check("rst_valid", M_VALID, 0);
        check("rst_data", DATA_OUT, 0);
        check("rst_last", M_LAST, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        expect_done = 0;
        prev_stall = 0;
      end else begin
        if (expect_done) begin
          check("done_pulse", DONE, 1);
          check("valid_after_last", M_VALID, 0);
          expect_done = 0;
        end else begin
          check("no_spurious_done", DONE, 0);
        end
        check("valid_vs_model", M_VALID, exp_q.size() != 0);
        check("busy_vs_model", BUSY, exp_q.size() != 0);
        if (prev_stall && M_VALID) begin
          check("hold_data", DATA_OUT, prev_data);
          check("hold_last", M_LAST, prev_last);
        end
        if (M_VALID && M_READY && exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("stream_data", DATA_OUT, w.data);
          check("stream_last", M_LAST, w.last);
          accepted++;
          if (w.last) expect_done = 1;
        end
        prev_stall = M_VALID && !M_READY;
        prev_data = DATA_OUT;
        prev_last = M_LAST;
      end
    end
  end

  initial begin
    int acc0;
    RESET_IN = 1'b1; START = 1'b0; WR_EN = 1'b0;
    WR_IDX = '0; WR_SEL = 2'd0; WR_DATA = '0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 'x; my[i] = 'x; mm[i] = 'x;
    end
    repeat (3) @(posedge CLK_IN);
    #1;
    RESET_IN = 1'b0;
    tick();

    for (int i = 0; i < N; i++) begin
      do_write(i, 2'd0, 16'(16'h1000 + i));
      do_write(i, 2'd1, 16'(16'h2000 + i));
      do_write(i, 2'd2, 16'(16'h3000 + i));
    end
    do_write(0, 2'd3, 16'hDEAD);

    // Full-rate stream
    ready_mode = 0;
    start_stream(0, 0, 2'd0, 16'h0);
    check("first_word", DATA_OUT, 16'h1000);
    check("first_valid", M_VALID, 1);
    wait_done("full_rate");

    // Back-pressure
    ready_mode = 1;
    start_stream(0, 0, 2'd0, 16'h0);
    wait_done("toggle_ready");
    ready_mode = 0;

    // START and write while streaming are ignored
    acc0 = accepted;
    start_stream(0, 0, 2'd0, 16'h0);
    wait_accepted(acc0 + 2, "wait_word2");
    START = 1'b1;
    do_write(3, 2'd0, 16'hFFFF);
    START = 1'b0;
    wait_done("start_in_stream");

    // Reset mid-stream
    acc0 = accepted;
    start_stream(0, 0, 2'd0, 16'h0);
    wait_accepted(acc0 + 5, "wait_word5");
    RESET_IN = 1'b1;
    exp_q.delete();
    in_stream = 0;
    #1;
    check("async_reset_valid", M_VALID, 0);
    tick();
    tick();
    RESET_IN = 1'b0;
    tick();
    start_stream(0, 0, 2'd0, 16'h0);
    check("restart_first", DATA_OUT, 16'h1000);
    wait_done("after_reset");

    // Write and START on the same edge
    start_stream(1, 0, 2'd0, 16'hABCD);
    check("same_edge_first", DATA_OUT, 16'h1000);
    wait_done("same_edge");
    start_stream(0, 0, 2'd0, 16'h0);
    check("second_first", DATA_OUT, 16'hABCD);
    wait_done("second_stream");

    // Randomized writes and back-pressure
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 5; k++)
        do_write($urandom_range(0, N - 1), 2'($urandom_range(0, 3)), 16'($urandom));
      ready_mode = $urandom_range(0, 2);
      start_stream(0, 0, 2'd0, 16'h0);
      wait_done("random_stream");
    end
    ready_mode = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
